// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit queue.
//   uart_tx_state_t - framer FSM state
//   UART_DATA_BITS  - payload bits per frame
//   UART_FRAME_BITS - start + data + stop bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: byte stream in, status and serial line out.
//   in_byte, in_byte_en   - producer side push (master drives)
//   full, busy, overflow  - queue status (slave drives)
//   txd                   - serial line, idle high (slave drives)
interface uart_tx_queue_if;

  logic [7:0] in_byte;
  logic       in_byte_en;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       txd;

  modport master (
    output in_byte,
    output in_byte_en,
    input  full,
    input  busy,
    input  overflow,
    input  txd
  );

  modport slave (
    input  in_byte,
    input  in_byte_en,
    output full,
    output busy,
    output overflow,
    output txd
  );

endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO with asynchronous active-high reset.
//   clk, reset - clock, async reset (empties the queue)
//   push       - write push_data when not full (ignored when full)
//   pop        - advance head when not empty (ignored when empty)
//   pop_data   - current head entry, valid while !empty
//   full/empty - decoded from the registered entry count
module byte_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  // One extra bit so a full queue is distinct from an empty one.
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: queued 8N1 UART transmitter, LSB first.
//   clk, reset - system clock, asynchronous active-high reset
//   bus        - slave side of uart_tx_queue_if:
//                in_byte/in_byte_en push, full/busy status,
//                sticky overflow on rejected push, txd serial line.
// Every bit lasts CLK_DIV cycles; frames run back to back while bytes remain.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 207,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_queue_if.slave   bus
);

  localparam int unsigned    CntW    = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] BaudLoad = CntW'(CLK_DIV - 1);
  localparam logic [2:0]     LastBit = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q;
  logic [CntW-1:0]           baud_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                idx_q;
  logic                      txd_q;
  logic                      overflow_q;

  logic                      fifo_pop;
  logic [7:0]                fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      baud_done;

  assign baud_done = (baud_q == '0);
  // Pop from IDLE, or straight out of the last stop-bit cycle for gapless frames.
  assign fifo_pop  = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  byte_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.in_byte_en),
    .push_data (bus.in_byte),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      // full reflects the pre-edge count, so a same-edge pop does not rescue the push.
      if (bus.in_byte_en && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (state_q != IDLE) begin
        baud_q <= baud_q - CntW'(1);
      end
      unique case (state_q)
        IDLE, STOP: begin
          if (fifo_pop) begin
            state_q <= START;
            shift_q <= fifo_data;
            baud_q  <= BaudLoad;
            idx_q   <= '0;
            txd_q   <= 1'b0;
          end else if (state_q == STOP && baud_done) begin
            state_q <= IDLE;
            baud_q  <= '0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q <= DATA;
            baud_q  <= BaudLoad;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_done) begin
            shift_q <= shift_q >> 1;
            baud_q  <= BaudLoad;
            if (idx_q == LastBit) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              // Next data bit is the one about to land in shift_q[0].
              txd_q <= shift_q[1];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.txd      = txd_q;
  assign bus.overflow = overflow_q;
  assign bus.full     = fifo_full;
  assign bus.busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue.
// A line monitor decodes every frame on the CLK_DIV=4 instance and compares it
// against bytes queued when accepted pushes were driven; a second instance with
// CLK_DIV=207 checks the start-bit width (time unit taken as 1 ns, 10 ns clock).
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int unsigned Div      = 4;
  localparam int unsigned Depth    = 4;
  localparam int unsigned Div2     = 207;
  localparam int unsigned Period   = 10;
  localparam int unsigned FrameCyc = UART_FRAME_BITS * Div;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;

  uart_tx_queue_if bus ();
  uart_tx_queue_if bus2 ();

  uart_tx_queue #(
    .CLK_DIV    (Div),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  uart_tx_queue #(
    .CLK_DIV    (Div2),
    .FIFO_DEPTH (Depth)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #(Period / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  sb[$];
  int unsigned frame_starts[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [7:0] b, input bit accepted);
    bus.in_byte    = b;
    bus.in_byte_en = 1'b1;
    if (accepted) sb.push_back(b);
    @(negedge clk);
  endtask

  task automatic idle_n(input int unsigned n);
    bus.in_byte_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.in_byte_en  = 1'b0;
    bus2.in_byte_en = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    frame_starts.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Line monitor: sample every cycle of a frame, require each bit to hold for
  // Div cycles, start=0, stop=1, then compare the payload with the scoreboard.
  initial begin : monitor
    logic [UART_FRAME_BITS-1:0] bits;
    logic                       shape_ok;
    logic                       aborted;
    forever begin
      @(negedge clk);
      if (!reset && bus.txd === 1'b0) begin
        frame_starts.push_back(cyc);
        shape_ok = 1'b1;
        aborted  = 1'b0;
        bits     = '0;
        for (int i = 0; i < FrameCyc; i++) begin
          if (i != 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (i % Div == 0) bits[i/Div] = bus.txd;
          else if (bus.txd !== bits[i/Div]) shape_ok = 1'b0;
        end
        if (!aborted) begin
          check_eq("frame_shape", {29'd0, shape_ok, bits[0], bits[UART_FRAME_BITS-1]}, 32'b101);
          check_eq("frame_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) check_eq("rx_byte", {24'd0, bits[8:1]}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin : main
    int unsigned e1;
    bit          saw_full;
    bit          saw_low;
    bit          found;
    int unsigned low_n;

    reset           = 1'b1;
    bus.in_byte     = '0;
    bus.in_byte_en  = 1'b0;
    bus2.in_byte    = '0;
    bus2.in_byte_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_txd", 32'(bus.txd), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
    check_eq("rst_txd2", 32'(bus2.txd), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Single byte into an idle queue.
    drive(8'h55, 1'b1);
    bus.in_byte_en = 1'b0;
    check_eq("t1_busy_after_push", 32'(bus.busy), 32'd1);
    check_eq("t1_txd_before_pop", 32'(bus.txd), 32'd1);
    @(negedge clk);
    check_eq("t1_txd_fall", 32'(bus.txd), 32'd0);
    repeat (FrameCyc - 1) @(negedge clk);
    check_eq("t1_busy_last_cycle", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_eq("t1_busy_fall", 32'(bus.busy), 32'd0);
    idle_n(4);
    check_eq("t1_drained", sb.size(), 32'd0);

    // Three-byte burst, frames back to back.
    frame_starts.delete();
    saw_full = 1'b0;
    drive(8'hA5, 1'b1);
    drive(8'h00, 1'b1);
    drive(8'hFF, 1'b1);
    bus.in_byte_en = 1'b0;
    for (int i = 0; i < 3 * FrameCyc + 10; i++) begin
      if (bus.full) saw_full = 1'b1;
      @(negedge clk);
    end
    check_eq("t2_full_never", 32'(saw_full), 32'd0);
    check_eq("t2_frames", frame_starts.size(), 32'd3);
    if (frame_starts.size() == 3) begin
      check_eq("t2_gap1", frame_starts[1] - frame_starts[0], FrameCyc);
      check_eq("t2_gap2", frame_starts[2] - frame_starts[1], FrameCyc);
    end
    check_eq("t2_drained", sb.size(), 32'd0);
    check_eq("t2_idle", 32'(bus.busy), 32'd0);

    // Fill to full, then a rejected sixth push.
    do_reset();
    drive(8'h11, 1'b1);
    drive(8'h22, 1'b1);
    drive(8'h33, 1'b1);
    drive(8'h44, 1'b1);
    drive(8'h55, 1'b1);
    check_eq("t3_full", 32'(bus.full), 32'd1);
    check_eq("t3_ovf_before", 32'(bus.overflow), 32'd0);
    drive(8'hEE, 1'b0);
    bus.in_byte_en = 1'b0;
    check_eq("t3_overflow", 32'(bus.overflow), 32'd1);
    check_eq("t3_full_held", 32'(bus.full), 32'd1);
    idle_n(6 * FrameCyc + 10);
    check_eq("t3_frames", frame_starts.size(), 32'd5);
    check_eq("t3_drained", sb.size(), 32'd0);
    check_eq("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
    check_eq("t3_idle", 32'(bus.busy), 32'd0);

    // Push on the exact edge the stop bit ends while full.
    do_reset();
    drive(8'h5A, 1'b1);
    e1 = cyc;
    drive(8'hC3, 1'b1);
    drive(8'h0F, 1'b1);
    drive(8'hF0, 1'b1);
    drive(8'h81, 1'b1);
    bus.in_byte_en = 1'b0;
    repeat (e1 + FrameCyc - cyc) @(negedge clk);
    check_eq("t4_full_before", 32'(bus.full), 32'd1);
    check_eq("t4_ovf_before", 32'(bus.overflow), 32'd0);
    drive(8'h99, 1'b0);
    bus.in_byte_en = 1'b0;
    check_eq("t4_overflow", 32'(bus.overflow), 32'd1);
    check_eq("t4_full_after_pop", 32'(bus.full), 32'd0);
    check_eq("t4_busy", 32'(bus.busy), 32'd1);
    idle_n(4 * FrameCyc + 10);
    check_eq("t4_frames", frame_starts.size(), 32'd5);
    if (frame_starts.size() >= 2) begin
      check_eq("t4_gap", frame_starts[1] - frame_starts[0], FrameCyc);
    end
    check_eq("t4_drained", sb.size(), 32'd0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    do_reset();
    drive(8'h3C, 1'b1);
    e1 = cyc;
    drive(8'h01, 1'b1);
    drive(8'h02, 1'b1);
    bus.in_byte_en = 1'b0;
    repeat (e1 + 18 - cyc) @(negedge clk);
    check_eq("t5_in_frame", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t5_txd", 32'(bus.txd), 32'd1);
    check_eq("t5_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    saw_low = 1'b0;
    for (int i = 0; i < 3 * FrameCyc; i++) begin
      @(negedge clk);
      if (bus.txd !== 1'b1) saw_low = 1'b1;
    end
    check_eq("t5_no_frames", 32'(saw_low), 32'd0);
    check_eq("t5_idle", 32'(bus.busy), 32'd0);

    // Start-bit width at CLK_DIV=207.
    bus2.in_byte    = 8'h41;
    bus2.in_byte_en = 1'b1;
    @(negedge clk);
    bus2.in_byte_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus2.txd === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t6_start_seen", 32'(found), 32'd1);
    low_n = 0;
    if (found) begin
      while (bus2.txd === 1'b0 && low_n < 2 * Div2) begin
        low_n++;
        @(negedge clk);
      end
    end
    check_eq("t6_start_width_ns", low_n * Period, 32'd2070);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte-serialising UART transmitter that consumes the CPU system's `out_byte`/`out_byte_en` stream and drives the board TX pin. A small FIFO absorbs bursts of console writes. An 8N1 framer shifts the bytes out LSB-first at a fixed divisor-derived baud rate. It sits directly downstream of the PicoRV32 system's byte output port, in the top level.

## Interface
- `CLK_DIV`, default 207: clocks per bit. 207 gives 2070 ns per bit at a 100 MHz clock. Legal range ≥ 2.
- `FIFO_DEPTH`, default 4: queue entries. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_byte`  in  8  byte to transmit.
- `in_byte_en`  in  1  push strobe; one byte per high cycle.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries; a push this cycle is rejected.
- `busy`  out  1  a frame is in flight or the FIFO is non-empty.
- `overflow`  out  1  sticky; set by any rejected push, cleared only by reset.
- `txd`  out  1  serial line, idle high.

## Operation
- Reset values:
  - `txd`=1, `full`=0, `busy`=0, `overflow`=0.
  - FSM in IDLE; FIFO empty, with read pointer, write pointer and count at 0.
  - Baud counter at 0; shift register at 0.
- Push:
  - On an edge with `in_byte_en`=1 and `full`=0, `in_byte` is written at the write pointer, the write pointer increments (wraps modulo `FIFO_DEPTH`) and count increments.
  - With `full`=1, the byte is dropped, `overflow` sets, and the FIFO is unchanged.
  - `full` is evaluated from the pre-edge count. A push is rejected while full even if a pop occurs on the same edge.
- Simultaneous push and pop (not full): count is unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on any edge where the FIFO is non-empty: pop the head into the shift register, load the baud counter with `CLK_DIV`-1, set the bit index to 0.
  - START: `txd`=0. When the baud counter hits 0 → DATA and reload the counter.
  - DATA: `txd`=shift[0]. When the counter hits 0: shift right; if bit index = 7 → STOP, else increment the index. Reload the counter in both cases.
  - STOP: `txd`=1. When the counter hits 0:
    - FIFO non-empty → START directly, popping as in IDLE. There is no idle bit between frames.
    - Otherwise → IDLE.
- The baud counter decrements by 1 every cycle outside IDLE. Its width is $clog2(`CLK_DIV`). Every bit lasts exactly `CLK_DIV` cycles.
- `busy` = (state ≠ IDLE) | (count ≠ 0).
- Reset mid-frame: `txd` returns high asynchronously, the partial frame is abandoned, and all queued bytes are discarded.

## Timing
- All outputs are registered, except `full` and `busy`, which are decoded from registered state with no input-to-output path.
- Latency: a byte pushed at edge E into an empty, idle queue pops at edge E+1, and `txd` falls after E+1.
- Frame length is 10×`CLK_DIV` cycles from the `txd` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Sustained throughput is one byte per 10×`CLK_DIV` cycles. Software must respect `full`, or bytes are lost and flagged.
- Count width is $clog2(`FIFO_DEPTH`)+1, so a full FIFO is distinct from an empty one.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_tx_state_t` (IDLE, START, DATA, STOP).
  - `UART_DATA_BITS`=8, `UART_FRAME_BITS`=10.
- One sub-module, `byte_fifo`: parameterised synchronous FIFO with async reset, push/pop/full/empty. The FSM and baud counter stay in `uart_tx_queue`.
- Expected size: 150–250 lines total.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4 unless stated.
- Single byte 0x55 pushed into an idle queue:
  - `txd` falls 1 cycle after the push edge.
  - Line sequence is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `busy` falls after 40 cycles.
- Burst of 0xA5, 0x00, 0xFF on consecutive cycles:
  - Three frames with no idle gap: 120 cycles of continuous framing.
  - Decoded bytes match in order; `full` never asserts.
- Five pushes on consecutive cycles while idle:
  - The first pops at once, so the remaining four fill the FIFO; `full`=1.
  - A sixth push while full sets `overflow`=1, and that byte is never transmitted.
- Push at the exact edge the STOP bit ends with the FIFO full:
  - The push is rejected and `overflow` sets.
  - The pop proceeds and count drops from 4 to 3.
- Assert `reset` during DATA bit 3 of 0x3C with two bytes queued:
  - Immediately `txd`=1, `busy`=0, `full`=0.
  - After release, no further frames are sent.
- With `CLK_DIV`=207, pushing 0x41 gives a start-bit low width of exactly 2070 ns at a 100 MHz clock.
